// File: rtl/bp_update_ctrl_pkg.sv
// Shared types for the branch-predictor update sequencer.
// Provides the queued update record, the controller state and the OBQ index width.
package bp_update_ctrl_pkg;

   localparam int IDX_W = 5;

   typedef struct packed {
      logic             taken;
      logic             correct;
      logic [31:0]      pc;
      logic [31:0]      target;
      logic [IDX_W-1:0] index;
   } BP_UPD_T;

   typedef enum logic {
      IDLE    = 1'b0,
      RECOVER = 1'b1
   } bp_ctrl_state_t;

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Retire, fetch-lookup and predictor-update bundle of bp_update_ctrl.
// master: retire/fetch/predictor side; slave: the controller.
interface bp_update_ctrl_if #(
   parameter int CNT_W = 3
);
   import bp_update_ctrl_pkg::*;

   logic [1:0]            rt_valid;
   logic [1:0]            rt_taken;
   logic [1:0]            rt_correct;
   logic [1:0][31:0]      rt_pc;
   logic [1:0][31:0]      rt_target;
   logic [1:0][IDX_W-1:0] rt_index;
   logic                  rt_stall;

   logic                  if_branch_req;
   logic [31:0]           if_pc_req;
   logic                  bp_if_branch;
   logic [31:0]           bp_if_pc_in;
   logic                  if_lookup_stall;

   logic                  bp_rt_en_branch;
   logic                  bp_rt_branch_taken;
   logic                  bp_rt_prediction_correct;
   logic [31:0]           bp_rt_pc;
   logic [31:0]           bp_rt_calculated_pc;
   logic [IDX_W-1:0]      bp_rt_branch_index;

   logic                  recover_busy;
   logic [CNT_W-1:0]      uq_count;

   modport master (
      output rt_valid, rt_taken, rt_correct,
      output rt_pc, rt_target, rt_index,
      input  rt_stall,
      output if_branch_req, if_pc_req,
      input  bp_if_branch, bp_if_pc_in, if_lookup_stall,
      input  bp_rt_en_branch, bp_rt_branch_taken,
      input  bp_rt_prediction_correct, bp_rt_pc,
      input  bp_rt_calculated_pc, bp_rt_branch_index,
      input  recover_busy, uq_count
   );

   modport slave (
      input  rt_valid, rt_taken, rt_correct,
      input  rt_pc, rt_target, rt_index,
      output rt_stall,
      input  if_branch_req, if_pc_req,
      output bp_if_branch, bp_if_pc_in, if_lookup_stall,
      output bp_rt_en_branch, bp_rt_branch_taken,
      output bp_rt_prediction_correct, bp_rt_pc,
      output bp_rt_calculated_pc, bp_rt_branch_index,
      output recover_busy, uq_count
   );

endinterface

// File: rtl/bp_upd_queue.sv
// 2-write / 1-read circular FIFO of branch updates with occupancy count.
// Ports: clk_i, rst_ni (sync, low), we_i/wd0_i/wd1_i writes, re_i pop, rd_o head, count_o.
module bp_upd_queue
   import bp_update_ctrl_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [1:0]       we_i,
   input  BP_UPD_T          wd0_i,
   input  BP_UPD_T          wd1_i,
   input  logic             re_i,
   output BP_UPD_T          rd_o,
   output logic [CNT_W-1:0] count_o
);

   BP_UPD_T          mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q, tail1;
   logic [CNT_W-1:0] cnt_q, n_enq;
   BP_UPD_T          first;

   // A lone slot-1 write still lands at the tail, keeping the queue dense.
   always_comb begin
      n_enq = CNT_W'(we_i[0]) + CNT_W'(we_i[1]);
      first = we_i[0] ? wd0_i : wd1_i;
      tail1 = tail_q + PTR_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (n_enq != '0) mem_q[tail_q] <= first;
      if (n_enq == CNT_W'(2)) mem_q[tail1] <= wd1_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         tail_q <= tail_q + PTR_W'(n_enq);
         if (re_i) head_q <= head_q + PTR_W'(1);
         cnt_q  <= cnt_q + n_enq - CNT_W'(re_i);
      end
   end

   assign rd_o    = mem_q[head_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/bp_update_ctrl.sv
// Retire-to-predictor update sequencer with post-mispredict lookup blocking.
// Ports: clock, reset (sync, low), enable, bus (slave side of bp_update_ctrl_if).
module bp_update_ctrl
   import bp_update_ctrl_pkg::*;
#(
   parameter  int UQ_DEPTH    = 4,
   parameter  int RECOVER_CYC = 2,
   localparam int CNT_W       = $clog2(UQ_DEPTH) + 1,
   localparam int RC_W        = $clog2(RECOVER_CYC + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   bp_update_ctrl_if.slave bus
);

   bp_ctrl_state_t   state_q, state_d;
   logic [RC_W-1:0]  rc_q, rc_d;
   logic [CNT_W-1:0] count;
   BP_UPD_T          head, wd0, wd1, upd_q;
   logic             en_q;
   logic [1:0]       we;
   logic             stall, pop, rec_done, busy;

   assign stall = count > CNT_W'(UQ_DEPTH - 2);

   // Slot 1 is younger than a mispredicted slot 0 and is squashed.
   always_comb begin
      wd0 = {bus.rt_taken[0], bus.rt_correct[0], bus.rt_pc[0],
             bus.rt_target[0], bus.rt_index[0]};
      wd1 = {bus.rt_taken[1], bus.rt_correct[1], bus.rt_pc[1],
             bus.rt_target[1], bus.rt_index[1]};
      we[0] = bus.rt_valid[0] && !stall;
      we[1] = bus.rt_valid[1] && !stall &&
              !(bus.rt_valid[0] && !bus.rt_correct[0]);
   end

   // The edge that closes a recovery window also pops.
   assign rec_done = (state_q == RECOVER) && (rc_q == RC_W'(1));
   assign pop      = enable && (count != '0) &&
                     ((state_q == IDLE) || rec_done);

   bp_upd_queue #(.DEPTH(UQ_DEPTH)) u_queue (
      .clk_i   (clock),
      .rst_ni  (reset),
      .we_i    (we),
      .wd0_i   (wd0),
      .wd1_i   (wd1),
      .re_i    (pop),
      .rd_o    (head),
      .count_o (count)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         rc_q    <= '0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rc_d    = rc_q;
      if (enable) begin
         if (state_q == RECOVER) begin
            rc_d = rc_q - RC_W'(1);
            if (rec_done) state_d = IDLE;
         end
         if (pop && !head.correct) begin
            state_d = RECOVER;
            rc_d    = RC_W'(RECOVER_CYC);
         end
      end
   end

   always_comb begin
      busy                = (state_q == RECOVER);
      bus.recover_busy    = busy;
      bus.if_lookup_stall = busy;
      bus.bp_if_branch    = bus.if_branch_req && !busy;
      bus.bp_if_pc_in     = bus.if_pc_req;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         en_q  <= 1'b0;
         upd_q <= '0;
      end else begin
         en_q <= pop;
         if (pop) upd_q <= head;
      end
   end

   assign bus.rt_stall                 = stall;
   assign bus.uq_count                 = count;
   assign bus.bp_rt_en_branch          = en_q;
   assign bus.bp_rt_branch_taken       = upd_q.taken;
   assign bus.bp_rt_prediction_correct = upd_q.correct;
   assign bus.bp_rt_pc                 = upd_q.pc;
   assign bus.bp_rt_calculated_pc      = upd_q.target;
   assign bus.bp_rt_branch_index       = upd_q.index;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl.
// Vector table plus hand sequences; a scoreboard checks every predictor update.
module tb_bp_update_ctrl;
   import bp_update_ctrl_pkg::*;

   localparam int CNT_W = 3;

   logic clock  = 1'b0;
   logic reset  = 1'b0;
   logic enable = 1'b1;
   int   checks = 0;
   int   errors = 0;

   bp_update_ctrl_if #(.CNT_W(CNT_W)) bus ();

   bp_update_ctrl #(.UQ_DEPTH(4), .RECOVER_CYC(2)) dut (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   BP_UPD_T sb[$];
   BP_UPD_T mon_e, mon_a;

   typedef struct {
      logic [1:0]  rv, tk, cr;
      logic [31:0] p0, p1, t0, t1;
      int          exp_cnt, exp_first, exp_rec;
   } vec_t;

   vec_t vt[7];

   task automatic check(input string name,
                        input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset && bus.bp_rt_en_branch) begin
         mon_a = {bus.bp_rt_branch_taken, bus.bp_rt_prediction_correct,
                  bus.bp_rt_pc, bus.bp_rt_calculated_pc,
                  bus.bp_rt_branch_index};
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL upd_unexpected act=%0h exp=none", mon_a);
         end else begin
            mon_e = sb.pop_front();
            check("upd", 128'(mon_a), 128'(mon_e));
         end
      end
   end

   task automatic retire(input logic [1:0] rv, tk, cr,
                         input logic [31:0] p0, p1, t0, t1,
                         input logic [IDX_W-1:0] i0, i1,
                         input bit push);
      BP_UPD_T u;
      bus.rt_valid     = rv;
      bus.rt_taken     = tk;
      bus.rt_correct   = cr;
      bus.rt_pc[0]     = p0;
      bus.rt_pc[1]     = p1;
      bus.rt_target[0] = t0;
      bus.rt_target[1] = t1;
      bus.rt_index[0]  = i0;
      bus.rt_index[1]  = i1;
      if (push) begin
         if (rv[0]) begin
            u = {tk[0], cr[0], p0, t0, i0};
            sb.push_back(u);
         end
         if (rv[1] && !(rv[0] && !cr[0])) begin
            u = {tk[1], cr[1], p1, t1, i1};
            sb.push_back(u);
         end
      end
      @(posedge clock);
      #1;
      bus.rt_valid = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          first, rec, mism, maxc;
      logic [7:0]  busy_m, en_m;

      vt[0] = '{2'b11, 2'b11, 2'b11, 32'h20, 32'h40, 32'h24, 32'h44, 2, 1, 0};
      vt[1] = '{2'b11, 2'b01, 2'b10, 32'h20, 32'h40, 32'h30, 32'h48, 1, 1, 2};
      vt[2] = '{2'b01, 2'b00, 2'b01, 32'h60, 32'h64, 32'h70, 32'h74, 1, 1, 0};
      vt[3] = '{2'b10, 2'b10, 2'b10, 32'h80, 32'h84, 32'h90, 32'h94, 1, 1, 0};
      vt[4] = '{2'b11, 2'b10, 2'b01, 32'hA0, 32'hA4, 32'hB0, 32'hB4, 2, 1, 2};
      vt[5] = '{2'b00, 2'b11, 2'b11, 32'hC0, 32'hC4, 32'hD0, 32'hD4, 0, -1, 0};
      vt[6] = '{2'b10, 2'b00, 2'b00, 32'hE0, 32'hE4, 32'hF0, 32'hF4, 1, 1, 2};

      bus.rt_valid      = '0;
      bus.rt_taken      = '0;
      bus.rt_correct    = '0;
      bus.rt_pc         = '0;
      bus.rt_target     = '0;
      bus.rt_index      = '0;
      bus.if_branch_req = 1'b0;
      bus.if_pc_req     = '0;

      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("rst_cnt",   128'(bus.uq_count), 128'(0));
      check("rst_en",    128'(bus.bp_rt_en_branch), 128'(0));
      check("rst_stall", 128'(bus.rt_stall), 128'(0));
      check("rst_busy",  128'(bus.recover_busy), 128'(0));

      for (int v = 0; v < 7; v++) begin
         first = -1;
         rec   = 0;
         mism  = 0;
         bus.if_branch_req = 1'b1;
         bus.if_pc_req     = 32'hABC0_0000 + 32'(v);
         retire(vt[v].rv, vt[v].tk, vt[v].cr,
                vt[v].p0, vt[v].p1, vt[v].t0, vt[v].t1,
                IDX_W'(2 * v), IDX_W'(2 * v + 1), 1'b1);
         for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (c == 0)
               check($sformatf("v%0d_cnt", v),
                     128'(bus.uq_count), 128'(vt[v].exp_cnt));
            if (bus.bp_rt_en_branch && first < 0) first = c;
            if (bus.recover_busy) rec++;
            if (bus.bp_if_branch !== !bus.recover_busy ||
                bus.if_lookup_stall !== bus.recover_busy ||
                bus.bp_if_pc_in !== bus.if_pc_req) mism++;
         end
         check($sformatf("v%0d_first", v), 128'(first), 128'(vt[v].exp_first));
         check($sformatf("v%0d_rec", v), 128'(rec), 128'(vt[v].exp_rec));
         check($sformatf("v%0d_gate", v), 128'(mism), 128'(0));
         check($sformatf("v%0d_sb", v), 128'(sb.size()), 128'(0));
      end
      bus.if_branch_req = 1'b0;

      // Reset mid-operation with three entries queued.
      enable = 1'b0;
      retire(2'b11, 2'b11, 2'b11, 32'h500, 32'h504, 32'h0, 32'h0,
             5'd1, 5'd2, 1'b0);
      retire(2'b01, 2'b01, 2'b01, 32'h508, 32'h0, 32'h0, 32'h0,
             5'd3, 5'd0, 1'b0);
      @(negedge clock);
      check("pre_rst_cnt", 128'(bus.uq_count), 128'(3));
      reset = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("mid_rst_cnt",   128'(bus.uq_count), 128'(0));
      check("mid_rst_en",    128'(bus.bp_rt_en_branch), 128'(0));
      check("mid_rst_stall", 128'(bus.rt_stall), 128'(0));
      check("mid_rst_busy",  128'(bus.recover_busy), 128'(0));
      check("mid_rst_pc",    128'(bus.bp_rt_pc), 128'(0));
      enable = 1'b1;
      repeat (3) @(negedge clock);
      check("mid_rst_drain", 128'(bus.uq_count), 128'(0));

      // Full queue, stall, ignored request, then drain.
      enable = 1'b0;
      retire(2'b11, 2'b11, 2'b11, 32'h100, 32'h104, 32'h110, 32'h114,
             5'd4, 5'd5, 1'b1);
      retire(2'b11, 2'b00, 2'b11, 32'h108, 32'h10C, 32'h118, 32'h11C,
             5'd6, 5'd7, 1'b1);
      @(negedge clock);
      check("full_cnt",   128'(bus.uq_count), 128'(4));
      check("full_stall", 128'(bus.rt_stall), 128'(1));
      retire(2'b11, 2'b11, 2'b11, 32'h200, 32'h204, 32'h0, 32'h0,
             5'd8, 5'd9, 1'b0);
      @(negedge clock);
      check("full_ignore", 128'(bus.uq_count), 128'(4));
      enable = 1'b1;
      @(negedge clock);
      check("drain1_cnt",   128'(bus.uq_count), 128'(3));
      check("drain1_stall", 128'(bus.rt_stall), 128'(1));
      @(negedge clock);
      check("drain2_cnt",   128'(bus.uq_count), 128'(2));
      check("drain2_stall", 128'(bus.rt_stall), 128'(0));
      repeat (6) @(negedge clock);
      check("full_sb", 128'(sb.size()), 128'(0));

      // Wrap-around with continuous drain.
      maxc = 0;
      for (int k = 0; k < 10; k++) begin
         retire(2'b01, 2'b01, 2'b01, 32'h400 + 32'(4 * k), 32'h0,
                32'h800 + 32'(4 * k), 32'h0, IDX_W'(k), 5'd0, 1'b1);
         if (int'(bus.uq_count) > maxc) maxc = int'(bus.uq_count);
      end
      repeat (4) begin
         @(negedge clock);
         if (int'(bus.uq_count) > maxc) maxc = int'(bus.uq_count);
      end
      check("wrap_max_over2", 128'(maxc > 2), 128'(0));
      check("wrap_sb", 128'(sb.size()), 128'(0));
      check("wrap_cnt", 128'(bus.uq_count), 128'(0));

      // Enable freeze in the middle of a recovery window.
      retire(2'b01, 2'b01, 2'b00, 32'h300, 32'h0, 32'h380, 32'h0,
             5'd20, 5'd0, 1'b1);
      retire(2'b01, 2'b01, 2'b01, 32'h304, 32'h0, 32'h384, 32'h0,
             5'd21, 5'd0, 1'b1);
      enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         busy_m[i] = bus.recover_busy;
         en_m[i]   = bus.bp_rt_en_branch;
         if (i == 3) enable = 1'b1;
      end
      check("frz_busy", 128'(busy_m), 128'(8'b0001_1111));
      check("frz_en",   128'(en_m),   128'(8'b0010_0001));

      // Back-to-back mispredicts each get a full window.
      retire(2'b01, 2'b00, 2'b00, 32'h600, 32'h0, 32'h680, 32'h0,
             5'd22, 5'd0, 1'b1);
      retire(2'b01, 2'b01, 2'b00, 32'h604, 32'h0, 32'h684, 32'h0,
             5'd23, 5'd0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         busy_m[i] = bus.recover_busy;
         en_m[i]   = bus.bp_rt_en_branch;
      end
      check("b2b_busy", 128'(busy_m), 128'(8'b0000_1111));
      check("b2b_en",   128'(en_m),   128'(8'b0000_0101));
      check("end_sb",   128'(sb.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
